// File: rtl/time_set_ctrl_pkg.sv
// Shared constants, FSM state type and the wrap-around increment used by the time-preset editor.
package time_set_pkg;

  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] SEC_MAX  = 8'd59;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] max_value);
    return (value >= max_value) ? 8'd0 : value + 8'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Key inputs and preset/pulse outputs of the time-set controller, bundled for module ports.
interface time_set_ctrl_if;

  logic       key_hour_raw;
  logic       key_min_raw;
  logic       key_sec_raw;
  logic       key_enter_raw;
  logic [7:0] hour_set;
  logic [7:0] min_set;
  logic [7:0] sec_set;
  logic       key_hour_up;
  logic       key_min_up;
  logic       key_sec_up;
  logic       key_enter;
  logic       editing;

  modport master (
    output key_hour_raw, key_min_raw, key_sec_raw, key_enter_raw,
    input  hour_set, min_set, sec_set,
    input  key_hour_up, key_min_up, key_sec_up, key_enter, editing
  );

  modport slave (
    input  key_hour_raw, key_min_raw, key_sec_raw, key_enter_raw,
    output hour_set, min_set, sec_set,
    output key_hour_up, key_min_up, key_sec_up, key_enter, editing
  );

endinterface

// File: rtl/time_set_ctrl_debounce.sv
// Two-flop synchronizer plus counter debouncer; press is a one-cycle pulse on a debounced rising edge.
module key_debounce #(
  parameter int DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          press_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b00;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      press_reg <= 1'b0;
      // Any sample agreeing with the current level restarts the stability count.
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/time_set_ctrl.sv
// Hour/minute/second preset editor with IDLE/EDIT mode tracking.
// Optional auto-repeat of held up keys is enabled by defining TIME_SET_AUTO_REPEAT_EN.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEB_CNT = 1000000,
  parameter int REP_DLY = 50000000,
  parameter int REP_PER = 20000000
) (
  input logic            clk,
  input logic            rst_n,
  time_set_ctrl_if.slave bus
);

  // Key index: 0 hour, 1 min, 2 sec, 3 enter.
  logic [3:0] raw_vec;
  logic [3:0] level_vec;
  logic [3:0] press_vec;
  logic [2:0] up_evt;
  logic       unused_level;

  assign raw_vec = {bus.key_enter_raw, bus.key_sec_raw, bus.key_min_raw, bus.key_hour_raw};

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_debounce #(
      .DEB_CNT(DEB_CNT)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_vec[gi]),
      .level(level_vec[gi]),
      .press(press_vec[gi])
    );
  end

  assign unused_level = ^level_vec;

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [2:0] rep_evt;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rep
    logic [RW-1:0] rep_cnt_reg;
    logic          rep_first_reg;
    logic [RW-1:0] rep_target;

    // The counter holds cycles elapsed since the last press or repeat while the key stays down.
    assign rep_target   = rep_first_reg ? RW'(REP_DLY) : RW'(REP_PER);
    assign rep_evt[gi]  = level_vec[gi] && !press_vec[gi] && (rep_cnt_reg == rep_target);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_reg   <= '0;
        rep_first_reg <= 1'b1;
      end else if (!level_vec[gi]) begin
        rep_cnt_reg   <= '0;
        rep_first_reg <= 1'b1;
      end else if (press_vec[gi]) begin
        rep_cnt_reg   <= RW'(1);
        rep_first_reg <= 1'b1;
      end else if (rep_evt[gi]) begin
        rep_cnt_reg   <= RW'(1);
        rep_first_reg <= 1'b0;
      end else begin
        rep_cnt_reg <= rep_cnt_reg + RW'(1);
      end
    end
  end

  assign up_evt = press_vec[2:0] | rep_evt;
`else
  localparam int unused_rep_cfg = REP_DLY + REP_PER;

  assign up_evt = press_vec[2:0];
`endif

  state_t     state_reg, state_next;
  logic [7:0] hour_reg, hour_next;
  logic [7:0] min_reg, min_next;
  logic [7:0] sec_reg, sec_next;
  logic [2:0] up_reg;
  logic       enter_reg;
  logic       editing_reg;

  always_comb begin
    state_next = state_reg;
    hour_next  = hour_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;
    // An up press always lands in EDIT, even when enter arrives on the same cycle.
    case (state_reg)
      IDLE: if (|up_evt) state_next = EDIT;
      EDIT: if (press_vec[3] && !(|up_evt)) state_next = IDLE;
    endcase
    if (up_evt[0]) hour_next = wrap_inc(hour_reg, HOUR_MAX);
    if (up_evt[1]) min_next  = wrap_inc(min_reg, MIN_MAX);
    if (up_evt[2]) sec_next  = wrap_inc(sec_reg, SEC_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      hour_reg    <= 8'd0;
      min_reg     <= 8'd0;
      sec_reg     <= 8'd0;
      up_reg      <= 3'b000;
      enter_reg   <= 1'b0;
      editing_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hour_reg    <= hour_next;
      min_reg     <= min_next;
      sec_reg     <= sec_next;
      up_reg      <= up_evt;
      enter_reg   <= press_vec[3];
      editing_reg <= (state_reg == EDIT);
    end
  end

  assign bus.hour_set    = hour_reg;
  assign bus.min_set     = min_reg;
  assign bus.sec_set     = sec_reg;
  assign bus.key_hour_up = up_reg[0];
  assign bus.key_min_up  = up_reg[1];
  assign bus.key_sec_up  = up_reg[2];
  assign bus.key_enter   = enter_reg;
  assign bus.editing     = editing_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a window-based debounce/repeat model checks every cycle,
// alongside a vector table, directed corner sequences and random key activity.
module tb_time_set_ctrl;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .DEB_CNT(DEB),
    .REP_DLY(RDLY),
    .REP_PER(RPER)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt[4];

  // Reference model state: raw sample history, debounced level, press times.
  int       edge_k;
  int       hist[4][$];
  bit       lvl[4];
  bit       rose[4];
  int       ptime[4];
  int       m_hour, m_min, m_sec;
  bit       m_in_edit, m_editing, m_enter;
  bit [2:0] m_up;

  typedef struct {
    logic [3:0] keys;
    int         hour;
    int         min;
    int         sec;
    bit         edit;
    logic [3:0] pulses;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [28:0] act_vec();
    return {bus.hour_set, bus.min_set, bus.sec_set,
            bus.key_hour_up, bus.key_min_up, bus.key_sec_up, bus.key_enter, bus.editing};
  endfunction

  function automatic logic [28:0] exp_vec();
    return {8'(m_hour), 8'(m_min), 8'(m_sec), m_up[0], m_up[1], m_up[2], m_enter, m_editing};
  endfunction

  task automatic set_keys(input logic [3:0] m);
    bus.key_hour_raw  = m[0];
    bus.key_min_raw   = m[1];
    bus.key_sec_raw   = m[2];
    bus.key_enter_raw = m[3];
  endtask

  task automatic model_reset();
    edge_k = 0;
    for (int i = 0; i < 4; i++) begin
      hist[i].delete();
      lvl[i]   = 1'b0;
      rose[i]  = 1'b0;
      ptime[i] = 0;
    end
    m_hour = 0; m_min = 0; m_sec = 0;
    m_in_edit = 1'b0; m_editing = 1'b0; m_enter = 1'b0; m_up = 3'b000;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_step();
    bit         fire, any_up, chg;
    int         since;
    logic [3:0] raw;
    if (!rst_n) begin
      model_reset();
    end else begin
      edge_k++;
      any_up = 1'b0;
      for (int i = 0; i < 3; i++) begin
        fire  = rose[i];
        since = edge_k - ptime[i];
        if (AUTO && lvl[i] && !rose[i] && since >= RDLY && ((since - RDLY) % RPER) == 0)
          fire = 1'b1;
        if (rose[i]) ptime[i] = edge_k;
        m_up[i] = fire;
        any_up |= fire;
      end
      if (m_up[0]) m_hour = (m_hour + 1) % 24;
      if (m_up[1]) m_min  = (m_min + 1) % 60;
      if (m_up[2]) m_sec  = (m_sec + 1) % 60;
      m_enter   = rose[3];
      m_editing = m_in_edit;
      if (any_up) m_in_edit = 1'b1;
      else if (m_enter) m_in_edit = 1'b0;
      // Level flips once the last DEB synchronized samples (raw delayed 2) all disagree with it.
      raw = {bus.key_enter_raw, bus.key_sec_raw, bus.key_min_raw, bus.key_hour_raw};
      for (int j = 0; j < 4; j++) begin
        hist[j].push_back(int'(raw[j]));
        if (hist[j].size() > DEB + 2) void'(hist[j].pop_front());
        chg = (hist[j].size() == DEB + 2);
        for (int d = 2; d <= DEB + 1; d++)
          if (hist[j][DEB + 1 - d] == int'(lvl[j])) chg = 1'b0;
        rose[j] = chg && !lvl[j];
        if (chg) lvl[j] = !lvl[j];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("cycle", 64'(act_vec()), 64'(exp_vec()));
    pulse_cnt[0] += int'(bus.key_hour_up);
    pulse_cnt[1] += int'(bus.key_min_up);
    pulse_cnt[2] += int'(bus.key_sec_up);
    pulse_cnt[3] += int'(bus.key_enter);
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
  endtask

  task automatic do_reset(input bit clear_raw);
    if (clear_raw) set_keys(4'b0000);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_outputs", 64'(act_vec()), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic press_keys(input logic [3:0] m);
    set_keys(m);
    repeat (12) tick();
    set_keys(4'b0000);
    repeat (10) tick();
  endtask

  initial begin
    logic [3:0] p;
    int         q[$];
    int         exp_t[5];
    int         hold_left[4];
    logic [3:0] rk;

    vecs[0] = '{4'b0001, 1, 0, 0, 1'b1, 4'b0001};
    vecs[1] = '{4'b0010, 1, 1, 0, 1'b1, 4'b0010};
    vecs[2] = '{4'b1000, 1, 1, 0, 1'b0, 4'b1000};
    vecs[3] = '{4'b1000, 1, 1, 0, 1'b0, 4'b1000};
    vecs[4] = '{4'b0110, 1, 2, 1, 1'b1, 4'b0110};
    vecs[5] = '{4'b1010, 1, 3, 1, 1'b1, 4'b1010};
    vecs[6] = '{4'b1111, 2, 4, 2, 1'b1, 4'b1111};
    vecs[7] = '{4'b1000, 2, 4, 2, 1'b0, 4'b1000};
    exp_t   = '{7, 27, 35, 43, 51};

    set_keys(4'b0000);
    #2;

    // Vector table
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      clear_pulses();
      press_keys(vecs[i].keys);
      p = vecs[i].pulses;
      check($sformatf("vec%0d_presets", i),
            {bus.hour_set, bus.min_set, bus.sec_set, bus.editing},
            {8'(vecs[i].hour), 8'(vecs[i].min), 8'(vecs[i].sec), vecs[i].edit});
      check($sformatf("vec%0d_pulses", i),
            {8'(pulse_cnt[3]), 8'(pulse_cnt[2]), 8'(pulse_cnt[1]), 8'(pulse_cnt[0])},
            {7'd0, p[3], 7'd0, p[2], 7'd0, p[1], 7'd0, p[0]});
    end

    // Clean hour press latency
    do_reset(1'b1);
    clear_pulses();
    set_keys(4'b0001);
    repeat (6) tick();
    check("hour_pulse_early", pulse_cnt[0], 0);
    tick();
    check("hour_pulse_at_7", {bus.key_hour_up, bus.hour_set}, {1'b1, 8'd1});
    tick();
    check("editing_after_hour", {bus.key_hour_up, bus.editing}, 2'b01);
    set_keys(4'b0000);
    repeat (10) tick();

    // Wrap-around
    do_reset(1'b1);
    repeat (23) press_keys(4'b0001);
    check("hour_23", bus.hour_set, 23);
    press_keys(4'b0001);
    check("hour_wrap", bus.hour_set, 0);
    repeat (60) press_keys(4'b0100);
    check("sec_wrap_min_kept", {bus.min_set, bus.sec_set}, 16'd0);

    // Bouncing min key
    do_reset(1'b1);
    clear_pulses();
    for (int c = 0; c < 20; c++) begin
      set_keys(((c / 2) % 2 == 0) ? 4'b0010 : 4'b0000);
      tick();
    end
    set_keys(4'b0010);
    repeat (16) tick();
    set_keys(4'b0000);
    repeat (12) tick();
    check("bounce_one_pulse", {8'(pulse_cnt[1]), bus.min_set}, {8'd1, 8'd1});

    // Enter exits edit; coinciding min+enter stays in edit
    do_reset(1'b1);
    press_keys(4'b0010);
    set_keys(4'b1000);
    repeat (7) tick();
    check("enter_pulse", {bus.key_enter, bus.editing}, 2'b11);
    tick();
    check("editing_falls", {bus.key_enter, bus.editing}, 2'b00);
    set_keys(4'b0000);
    repeat (10) tick();
    press_keys(4'b0001);
    set_keys(4'b1010);
    repeat (7) tick();
    check("min_enter_aligned", {bus.key_min_up, bus.key_enter, bus.min_set}, {1'b1, 1'b1, 8'd2});
    repeat (6) tick();
    check("editing_stays", bus.editing, 1);
    set_keys(4'b0000);
    repeat (10) tick();

    // Reset in the middle of a debounce
    do_reset(1'b1);
    repeat (5) press_keys(4'b0100);
    check("sec_before_reset", bus.sec_set, 5);
    set_keys(4'b0100);
    repeat (3) tick();
    do_reset(1'b1);
    clear_pulses();
    repeat (15) tick();
    check("no_sec_pulse_after_reset", {8'(pulse_cnt[2]), bus.sec_set}, 16'd0);

    // Key held through reset release
    set_keys(4'b0001);
    do_reset(1'b0);
    clear_pulses();
    repeat (6) tick();
    check("held_reset_early", pulse_cnt[0], 0);
    tick();
    check("held_reset_press", {bus.key_hour_up, bus.hour_set}, {1'b1, 8'd1});
    set_keys(4'b0000);
    repeat (10) tick();

    // Auto-repeat timing
    do_reset(1'b1);
    set_keys(4'b0100);
    for (int t = 1; t <= 65; t++) begin
      if (t == 51) set_keys(4'b0000);
      tick();
      if (bus.key_sec_up) q.push_back(t);
    end
    check("repeat_count", q.size(), AUTO ? 5 : 1);
    check("repeat_sec_set", bus.sec_set, AUTO ? 5 : 1);
    for (int i = 0; i < (AUTO ? 5 : 1); i++)
      if (i < q.size()) check($sformatf("repeat_time%0d", i), q[i], exp_t[i]);

    // Random key activity against the model
    do_reset(1'b1);
    rk = 4'b0000;
    for (int k = 0; k < 4; k++) hold_left[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold_left[k] == 0) begin
          rk[k]        = 1'($urandom_range(0, 1));
          hold_left[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(4, 40));
        end
        hold_left[k]--;
      end
      set_keys(rk);
      if (c == 2000) do_reset(1'b0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 1000000, debounce stable-time in clk cycles (10 ms at 100 MHz).
REQ-002 Parameter REP_DLY, default 50000000, hold time in cycles before the first auto-repeat.
REQ-003 Parameter REP_PER, default 20000000, auto-repeat period in cycles.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 key_hour_raw, key_min_raw, key_sec_raw, key_enter_raw  in  1 each  raw push-buttons, active-high, asynchronous, bouncing.
REQ-007 hour_set  out  8  hour preset, binary, range 0..23.
REQ-008 min_set, sec_set  out  8 each  minute and second presets, binary, range 0..59.
REQ-009 key_hour_up, key_min_up, key_sec_up, key_enter  out  1 each  one-cycle press pulses, feeding the countdown timer's key inputs.
REQ-010 editing  out  1  high while the FSM is in EDIT.

Function
REQ-011 Each raw key SHALL pass a 2-flop synchronizer, then a debouncer that updates its debounced level only after the synchronized input has differed from it for DEB_CNT consecutive cycles; any bounce restarts the count.
REQ-012 A debounced rising edge SHALL produce a press event; press pulse and preset update SHALL appear on the same clock edge, exactly DEB_CNT+3 cycles after a clean raw rising edge.
REQ-013 Debounced falling edges SHALL produce no event.
REQ-014 Hour press: hour_set +1, wrapping 23->0; min press: min_set +1, 59->0; sec press: sec_set +1, 59->0; no carry between fields.
REQ-015 Simultaneous presses on different up keys in one cycle SHALL each update their own field and each pulse.
REQ-016 FSM states IDLE, EDIT. IDLE: any up press -> EDIT. EDIT: enter press with no up press in the same cycle -> IDLE; otherwise stay.
REQ-017 An enter press SHALL pulse key_enter in either state; if enter and an up press coincide, the up press wins the transition (state EDIT) and key_enter still pulses.
REQ-018 Presets SHALL hold their values across IDLE/EDIT transitions; only presses and reset change them.
REQ-019 editing SHALL be registered and equal (state==EDIT).

Reset
REQ-020 On rst_n low: hour_set, min_set, sec_set = 0; all pulse outputs and editing = 0; state IDLE; synchronizers, debounce levels, debounce and repeat counters = 0.
REQ-021 Reset asserted mid-debounce or mid-hold SHALL discard the pending event; a key held through reset release SHALL register as one press DEB_CNT+3 cycles after release.

Configuration
REQ-022 Macro TIME_SET_AUTO_REPEAT_EN defined: an up key held debounced-high SHALL generate a repeat press REP_DLY cycles after its initial press, then every REP_PER cycles until released; repeats behave as presses (pulse, wrap, FSM); key_enter never repeats.
REQ-023 Macro undefined: exactly one press per debounced rising edge; repeat counters and REP_DLY/REP_PER logic are absent.

Structure
REQ-024 Package time_set_pkg SHALL hold HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59 and the FSM state typedef (IDLE, EDIT).
REQ-025 Sub-module key_debounce (synchronizer + debounce + rising-edge pulse, parameter DEB_CNT) SHALL be instantiated four times; increment, wrap, repeat and FSM logic remain in time_set_ctrl.

Verification (DEB_CNT=4, REP_DLY=20, REP_PER=8 in simulation)
REQ-026 Clean hour press from reset -> key_hour_up pulses once at cycle 7 after the raw edge, hour_set=1, editing=1.
REQ-027 23 hour presses -> hour_set=23; 24th press -> hour_set=0; 60 sec presses -> sec_set=0, min_set unchanged.
REQ-028 Raw min key toggling every 2 cycles for 20 cycles, then stable high -> exactly one key_min_up pulse, min_set=1.
REQ-029 Min press, then enter press -> editing falls the cycle after the key_enter pulse; min/enter raw edges aligned -> min_set +1, key_enter pulses, editing stays 1.
REQ-030 rst_n pulsed low with sec_set=5 and sec key mid-debounce -> all outputs 0 and no key_sec_up pulse.
REQ-031 With TIME_SET_AUTO_REPEAT_EN, sec held 50 cycles after its press -> pulses at press, +20, +28, +36, +44 (sec_set=5); without the macro -> sec_set=1.
